// File: rtl/add32.sv
// add32 -- registered 32-bit adder built from a two-level carry-lookahead tree.
//
// The sum is produced by eight 4-bit lookahead groups. Each group forms
// per-bit generate/propagate terms and its own group generate/propagate.
// A second-level lookahead network turns those group terms into the carry
// into each group. The first four groups are combined into one block, and
// the last four into another, so the upper block's carry-in comes out of a
// single two-term lookahead equation rather than a ripple through eight groups.
//
// The carry into bit 0 is tied to 0. The result and its flags are captured
// on a cycle where in_valid is high and held otherwise. There is no
// combinational path from any input to any output.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous, active-low reset
//   in_valid   srca/srcb are captured on this edge
//   srca       operand A (unsigned or two's complement)
//   srcb       operand B (unsigned or two's complement)
//   aluout     registered (srca + srcb) mod 2^32
//   out_valid  high for the cycle after a capture
//   carry      registered unsigned carry-out of bit 31
//   overflow   registered signed overflow
//   zero       registered aluout == 0
//   negative   registered aluout[31]
module add32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic [31:0] aluout,
  output logic        out_valid,
  output logic        carry,
  output logic        overflow,
  output logic        zero,
  output logic        negative
);

  logic [31:0] bit_g;
  logic [31:0] bit_p;
  logic [31:0] sum;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [8:0]  grp_c;
  logic        blk_g_lo;
  logic        blk_p_lo;
  logic        blk_g_hi;
  logic        blk_p_hi;
  logic        sum_carry;
  logic        sum_ovf;

  assign bit_g = srca & srcb;
  assign bit_p = srca ^ srcb;

  // ---------------------------------------------------------------------
  // First level: eight 4-bit lookahead groups. Every internal carry is
  // expanded in terms of the group carry-in, so nothing ripples inside a group.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int B = 4 * gi;

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = bit_g[B+3:B];
    assign p = bit_p[B+3:B];

    assign c[0] = grp_c[gi];
    assign c[1] = g[0]
                | (p[0] & c[0]);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & c[0]);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);

    assign grp_g[gi] = g[3]
                     | (p[3] & g[2])
                     | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p[gi] = &p;

    assign sum[B+3:B] = p ^ c;
  end

  // ---------------------------------------------------------------------
  // Second level: lookahead over the group terms.
  // Groups 0..3 form the low block and groups 4..7 form the high block.
  // Each block resolves its own group carries from the block carry-in.
  // ---------------------------------------------------------------------
  assign grp_c[0] = 1'b0;

  assign grp_c[1] = grp_g[0]
                  | (grp_p[0] & grp_c[0]);
  assign grp_c[2] = grp_g[1]
                  | (grp_p[1] & grp_g[0])
                  | (grp_p[1] & grp_p[0] & grp_c[0]);
  assign grp_c[3] = grp_g[2]
                  | (grp_p[2] & grp_g[1])
                  | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);

  assign blk_g_lo = grp_g[3]
                  | (grp_p[3] & grp_g[2])
                  | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
  assign blk_p_lo = &grp_p[3:0];

  assign grp_c[4] = blk_g_lo | (blk_p_lo & grp_c[0]);

  assign grp_c[5] = grp_g[4]
                  | (grp_p[4] & grp_c[4]);
  assign grp_c[6] = grp_g[5]
                  | (grp_p[5] & grp_g[4])
                  | (grp_p[5] & grp_p[4] & grp_c[4]);
  assign grp_c[7] = grp_g[6]
                  | (grp_p[6] & grp_g[5])
                  | (grp_p[6] & grp_p[5] & grp_g[4])
                  | (grp_p[6] & grp_p[5] & grp_p[4] & grp_c[4]);

  assign blk_g_hi = grp_g[7]
                  | (grp_p[7] & grp_g[6])
                  | (grp_p[7] & grp_p[6] & grp_g[5])
                  | (grp_p[7] & grp_p[6] & grp_p[5] & grp_g[4]);
  assign blk_p_hi = &grp_p[7:4];

  // Carry out of bit 31. It is resolved at the top level from the two
  // block terms, so it never waits on the individual group carries.
  assign grp_c[8] = blk_g_hi
                  | (blk_p_hi & blk_g_lo)
                  | (blk_p_hi & blk_p_lo & grp_c[0]);

  assign sum_carry = grp_c[8];

  // Signed overflow: both operands have the same sign and the result has
  // the other sign. This is independent of the unsigned carry.
  assign sum_ovf = (srca[31] == srcb[31]) && (sum[31] != srca[31]);

  // ---------------------------------------------------------------------
  // Output register. The result and flags only move on a capture edge.
  // out_valid is a one-cycle echo of in_valid.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluout    <= 32'h0000_0000;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      negative  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        aluout   <= sum;
        carry    <= sum_carry;
        overflow <= sum_ovf;
        zero     <= (sum == 32'h0000_0000);
        negative <= sum[31];
      end
    end
  end

  // zero and negative are stored separately from aluout. They must never
  // drift from it.
  a_zero_consistent : assert property (@(posedge clk) disable iff (!rst_n)
    zero == (aluout == 32'h0000_0000));
  a_neg_consistent : assert property (@(posedge clk) disable iff (!rst_n)
    negative == aluout[31]);

endmodule

// File: tb/tb_add32.sv
module tb_add32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] aluout;
  logic        out_valid;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;

  add32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .srca      (srca),
    .srcb      (srcb),
    .aluout    (aluout),
    .out_valid (out_valid),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cy;
    logic        ovf;
    logic        zf;
    logic        nf;
  } exp_t;

  exp_t q[$];
  exp_t last;
  logic exp_v;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    s     = {1'b0, a} + {1'b0, b};
    e.sum = s[31:0];
    e.cy  = s[32];
    e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
    e.zf  = (s[31:0] == 32'h0);
    e.nf  = s[31];
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.sum = 32'h0;
    e.cy  = 1'b0;
    e.ovf = 1'b0;
    e.zf  = 1'b1;
    e.nf  = 1'b0;
    return e;
  endfunction

  // Expected out_valid: in_valid as seen on the previous capture edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_v <= 1'b0;
    else        exp_v <= in_valid;
  end

  // Scoreboard monitor. A valid cycle pops the next expected result.
  // An idle cycle must still show the last result.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      if (exp_v) begin
        if (q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else last = q.pop_front();
      end
      check("aluout",   aluout,               last.sum);
      check("carry",    {31'b0, carry},       {31'b0, last.cy});
      check("overflow", {31'b0, overflow},    {31'b0, last.ovf});
      check("zero",     {31'b0, zero},        {31'b0, last.zf});
      check("negative", {31'b0, negative},    {31'b0, last.nf});
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    srca     = a;
    srcb     = b;
    q.push_back(model(a, b));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    srca     = $urandom;
    srcb     = $urandom;
  endtask

  task automatic check_out(input string tag, input logic [31:0] s, input logic v,
                           input logic cy, input logic ovf, input logic zf, input logic nf);
    check({tag, "_sum"}, aluout, s);
    check({tag, "_vld"}, {31'b0, out_valid}, {31'b0, v});
    check({tag, "_cy"},  {31'b0, carry},     {31'b0, cy});
    check({tag, "_ovf"}, {31'b0, overflow},  {31'b0, ovf});
    check({tag, "_z"},   {31'b0, zero},      {31'b0, zf});
    check({tag, "_n"},   {31'b0, negative},  {31'b0, nf});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    checks   = 0;
    failures = 0;
    last     = reset_exp();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    srca     = 32'hDEAD_BEEF;
    srcb     = 32'h1234_5678;

    // Reset must hold the registers even with in_valid high and clocks running.
    repeat (3) @(posedge clk);
    #2;
    check_out("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    drive(32'h0000_0EFF, 32'h0000_0234);
    idle();
    @(negedge clk);
    check_out("r24", 32'h0000_1133, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a cycle while the result is showing.
    #2;
    rst_n = 1'b0;
    last  = reset_exp();
    q.delete();
    #1;
    check_out("arst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'd5, 32'd7);
    idle();
    @(negedge clk);
    check_out("r28", 32'h0000_000C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(32'hFFFF_FFFF, 32'h0000_0001);
    idle();
    @(negedge clk);
    check_out("r25", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    drive(32'h7FFF_FFFF, 32'h0000_0001);
    idle();
    @(negedge clk);
    check_out("r26a", 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(32'h8000_0000, 32'h8000_0000);
    idle();
    @(negedge clk);
    check_out("r26b", 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    drive(32'h1, 32'h2);
    drive(32'h10, 32'h20);
    drive(32'hFFFF_0000, 32'h0000_FFFF);
    idle();
    @(negedge clk);
    check_out("r27_last", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_out("r27_hold", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random run with corner-biased operands and random idle cycles.
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'h7FFF_FFFF;
        2:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'h0000_0001;
        1:       b = ~a + 32'd1;
        2:       b = ~a;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) idle();
      drive(a, b);
    end
    idle();
    repeat (2) @(negedge clk);
    check("sb_drain", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add32.md
ADD32 -- requirements
Module: add32

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; the block SHALL have one clock and this reset is asynchronous and active-low.
REQ-004 in_valid  input  1  qualifies srca/srcb for capture this cycle.
REQ-005 srca  input  32  operand A, unsigned or two's complement.
REQ-006 srcb  input  32  operand B, unsigned or two's complement.
REQ-007 aluout  output  32  registered sum srca + srcb, modulo 2^32.
REQ-008 out_valid  output  1  high for exactly the cycle(s) in which aluout holds a result captured from an in_valid cycle.
REQ-009 carry  output  1  registered unsigned carry-out of bit 31.
REQ-010 overflow  output  1  registered signed overflow: operands same sign, sum sign differs.
REQ-011 zero  output  1  registered flag, high when aluout == 0.
REQ-012 negative  output  1  registered copy of aluout[31].

Function
REQ-013 Sum SHALL be computed by a carry-lookahead structure: eight 4-bit CLA groups (per-bit generate g=a&b, propagate p=a^b), group generate/propagate, and a second-level lookahead unit producing group carries; ripple-carry or a single behavioural "+" for the full 32 bits SHALL NOT be used.
REQ-014 Carry-in to bit 0 SHALL be constant 0.
REQ-015 Latency SHALL be exactly one clock: operands with in_valid=1 at rising edge N appear on aluout/flags with out_valid=1 after edge N.
REQ-016 Throughput SHALL be one operation per cycle; back-to-back in_valid cycles SHALL produce back-to-back results with no bubbles.
REQ-017 When in_valid=0 at an edge, aluout and all flags SHALL hold their previous values and out_valid SHALL go to 0 for that cycle.
REQ-018 Wrap-around: sum bits above bit 31 SHALL be discarded into carry; aluout SHALL equal (srca+srcb) mod 2^32.
REQ-019 zero SHALL be derived from the computed sum, so that 0xFFFFFFFF + 0x00000001 yields zero=1, carry=1.
REQ-020 overflow SHALL equal (srca[31]==srcb[31]) && (sum[31]!=srca[31]), independent of carry.
REQ-021 Inputs SHALL not be required stable outside the capture edge; no combinational path SHALL exist from inputs to outputs.

Reset
REQ-022 While rst_n=0, aluout SHALL be 32'h00000000, carry=0, overflow=0, negative=0, out_valid=0, and zero=1 (consistent with aluout==0); assertion takes effect without a clock edge.
REQ-023 Reset asserted mid-operation SHALL discard any in-flight result; the first edge after rst_n deasserts SHALL capture normally if in_valid=1.

Verification
REQ-024 srca=0x00000EFF, srcb=0x00000234, in_valid=1 -> next cycle aluout=0x00001133, carry=0, overflow=0, zero=0, negative=0, out_valid=1.
REQ-025 srca=0xFFFFFFFF, srcb=0x00000001 -> aluout=0x00000000, carry=1, zero=1, overflow=0, negative=0.
REQ-026 srca=0x7FFFFFFF, srcb=0x00000001 -> aluout=0x80000000, overflow=1, negative=1, carry=0; then srca=0x80000000, srcb=0x80000000 -> aluout=0, overflow=1, carry=1, zero=1.
REQ-027 Three back-to-back in_valid cycles (1+2, 0x10+0x20, 0xFFFF0000+0x0000FFFF) followed by in_valid=0 -> results 0x3, 0x30, 0xFFFFFFFF on consecutive cycles, then out_valid=0 with aluout holding 0xFFFFFFFF.
REQ-028 Assert rst_n=0 asynchronously between clock edges while aluout=0x1133 -> aluout=0, zero=1, out_valid=0 immediately; release and apply 5+7 -> aluout=0x0000000C next cycle.
REQ-029 Randomized run of at least 10,000 operand pairs -> aluout, carry, overflow, zero, negative match a 33-bit reference sum every cycle.
